// File: rtl/clock_pkg.sv
// Shared time-of-day types, digit limits and the time-validity check used by
// both the time-of-day counter and the alarm logic.
package clock_pkg;

  typedef logic [3:0] bcd_digit_t;

  // hh:mm:ss as six BCD digits; packed order matches the 24-bit bus layout
  typedef struct packed {
    bcd_digit_t hour_tens;
    bcd_digit_t hour_units;
    bcd_digit_t min_tens;
    bcd_digit_t min_units;
    bcd_digit_t sec_tens;
    bcd_digit_t sec_units;
  } tod_t;

  localparam bcd_digit_t MAX_UNITS         = 4'd9;
  localparam bcd_digit_t MAX_SEC_TENS      = 4'd5;
  localparam bcd_digit_t MAX_MIN_TENS      = 4'd5;
  localparam bcd_digit_t MAX_HOUR_TENS     = 4'd2;
  localparam bcd_digit_t MAX_HOUR_UNITS_20 = 4'd3;  // last hour unit once tens is 2
  localparam tod_t       MIDNIGHT          = '0;

  // True when t is a legal 24-hour time (00:00:00 .. 23:59:59)
  function automatic logic time_is_valid(input tod_t t);
    logic hour_ok;
    hour_ok = ((t.hour_tens < MAX_HOUR_TENS) && (t.hour_units <= MAX_UNITS)) ||
              ((t.hour_tens == MAX_HOUR_TENS) && (t.hour_units <= MAX_HOUR_UNITS_20));
    return hour_ok &&
           (t.min_tens  <= MAX_MIN_TENS) && (t.min_units <= MAX_UNITS) &&
           (t.sec_tens  <= MAX_SEC_TENS) && (t.sec_units <= MAX_UNITS);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick enable every TICK_DIV cycles while en=1.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int               CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  // Phase counter: 0..TICK_DIV-1 while enabled, frozen otherwise
  always_ff @(posedge clk) begin
    // NOTE: registers are written with <= so every flop samples pre-edge values.
    if (reset) begin
      count <= '0;
    end else if (en) begin
      if (count == LAST) count <= '0;
      else               count <= count + CNT_W'(1);
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/time_of_day_counter.sv
// 24-hour BCD time-of-day counter with load port, carry strobes and a
// combinational 12/24-hour display decode.
module time_of_day_counter
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        mode_12h,
  input  logic        load_valid,
  input  logic [23:0] load_time,
  output logic        load_ready,
  output logic        load_err,
  output logic [23:0] time_bcd,
  output logic        pm,
  output logic        sec_pulse,
  output logic        min_pulse,
  output logic        day_pulse
);

  tod_t tod_q;
  tod_t tod_inc;
  tod_t load_tod;
  logic tick;
  logic load_accept;
  logic load_ok;
  logic load_apply;
  logic advance;
  logic sec_wrap;
  logic day_wrap;
  logic [4:0] hour_bin;
  logic [4:0] hour_disp;

  assign load_tod    = tod_t'(load_time);
  assign load_ready  = !reset;
  assign load_accept = load_valid && load_ready;
  assign load_ok     = time_is_valid(load_tod);
  assign load_apply  = load_accept && load_ok;
  // Any accepted load owns the cycle; a coincident tick is dropped
  assign advance     = tick && !load_accept;

  // A valid load restarts the second phase, so it shares the prescaler clear
  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset || load_apply),
    .en    (run),
    .tick  (tick)
  );

  // One-second increment with the full BCD carry chain
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    tod_inc  = tod_q;
    sec_wrap = 1'b0;
    day_wrap = 1'b0;
    if (tod_q.sec_units != MAX_UNITS) begin
      tod_inc.sec_units = tod_q.sec_units + 4'd1;
    end else begin
      tod_inc.sec_units = 4'd0;
      if (tod_q.sec_tens != MAX_SEC_TENS) begin
        tod_inc.sec_tens = tod_q.sec_tens + 4'd1;
      end else begin
        tod_inc.sec_tens = 4'd0;
        sec_wrap         = 1'b1;
        if (tod_q.min_units != MAX_UNITS) begin
          tod_inc.min_units = tod_q.min_units + 4'd1;
        end else begin
          tod_inc.min_units = 4'd0;
          if (tod_q.min_tens != MAX_MIN_TENS) begin
            tod_inc.min_tens = tod_q.min_tens + 4'd1;
          end else begin
            tod_inc.min_tens = 4'd0;
            if ((tod_q.hour_tens == MAX_HOUR_TENS) &&
                (tod_q.hour_units == MAX_HOUR_UNITS_20)) begin
              tod_inc.hour_tens  = 4'd0;
              tod_inc.hour_units = 4'd0;
              day_wrap           = 1'b1;
            end else if (tod_q.hour_units == MAX_UNITS) begin
              tod_inc.hour_units = 4'd0;
              tod_inc.hour_tens  = tod_q.hour_tens + 4'd1;
            end else begin
              tod_inc.hour_units = tod_q.hour_units + 4'd1;
            end
          end
        end
      end
    end
  end

  // Time register: reset, then load, then advance
  always_ff @(posedge clk) begin
    if (reset)           tod_q <= MIDNIGHT;
    else if (load_apply) tod_q <= load_tod;
    else if (advance)    tod_q <= tod_inc;
  end

  // Carry strobes, aligned with the first cycle the new time is visible
  always_ff @(posedge clk) begin
    if (reset) begin
      sec_pulse <= 1'b0;
      min_pulse <= 1'b0;
      day_pulse <= 1'b0;
    end else begin
      sec_pulse <= advance;
      min_pulse <= advance && sec_wrap;
      day_pulse <= advance && day_wrap;
    end
  end

  // Rejection strobe for an accepted out-of-range load
  always_ff @(posedge clk) begin
    if (reset) load_err <= 1'b0;
    else       load_err <= load_accept && !load_ok;
  end

  // Display decode: 24-hour pass-through or 12-hour hour remap with pm flag
  always_comb begin
    hour_bin  = 5'(tod_q.hour_tens) * 5'd10 + 5'(tod_q.hour_units);
    hour_disp = hour_bin;
    if (hour_bin == 5'd0)       hour_disp = 5'd12;
    else if (hour_bin > 5'd12)  hour_disp = hour_bin - 5'd12;
    time_bcd = tod_q;
    pm       = 1'b0;
    if (mode_12h) begin
      pm = (hour_bin >= 5'd12);
      if (hour_disp >= 5'd10) begin
        time_bcd[23:20] = 4'd1;
        time_bcd[19:16] = 4'(hour_disp - 5'd10);
      end else begin
        time_bcd[23:20] = 4'd0;
        time_bcd[19:16] = 4'(hour_disp);
      end
    end
  end

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed bench for time_of_day_counter with TICK_DIV=4. Each step drives one
// cycle of stimulus, pushes the expected post-edge outputs from an integer
// reference model, and pops/compares them on the following falling edge.
module tb_time_of_day_counter;

  localparam int TICK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        mode_12h = 1'b0;
  logic        load_valid = 1'b0;
  logic [23:0] load_time = '0;
  logic        load_ready;
  logic        load_err;
  logic [23:0] time_bcd;
  logic        pm;
  logic        sec_pulse;
  logic        min_pulse;
  logic        day_pulse;

  always #5 clk = ~clk;

  time_of_day_counter #(
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .mode_12h   (mode_12h),
    .load_valid (load_valid),
    .load_time  (load_time),
    .load_ready (load_ready),
    .load_err   (load_err),
    .time_bcd   (time_bcd),
    .pm         (pm),
    .sec_pulse  (sec_pulse),
    .min_pulse  (min_pulse),
    .day_pulse  (day_pulse)
  );

  typedef struct packed {
    logic [23:0] t;
    logic        pm;
    logic        sp;
    logic        mp;
    logic        dp;
    logic        err;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state: plain integers, independent of BCD encoding
  int m_h = 0, m_m = 0, m_s = 0, m_pre = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] fmt(input int h, input int m, input int s, input logic m12);
    int hd;
    hd = h;
    if (m12) begin
      hd = h % 12;
      if (hd == 0) hd = 12;
    end
    return {4'(hd / 10), 4'(hd % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic bit bcd_ok(input logic [23:0] v);
    int ht, hu, mt, mu, st, su;
    ht = int'(v[23:20]); hu = int'(v[19:16]);
    mt = int'(v[15:12]); mu = int'(v[11:8]);
    st = int'(v[7:4]);   su = int'(v[3:0]);
    return (hu <= 9) && (ht * 10 + hu <= 23) && (mt <= 5) && (mu <= 9) &&
           (st <= 5) && (su <= 9);
  endfunction

  // One clock of stimulus; entered and left on a falling edge
  task automatic step(input logic rst, input logic lv, input logic [23:0] lt,
                      input logic r, input logic m12, input string tag);
    exp_t e;
    exp_t got;
    string tg;
    bit acc, ok, tk;
    reset = rst; load_valid = lv; load_time = lt; run = r; mode_12h = m12;
    #1;
    check({tag, " load_ready"}, 32'(load_ready), 32'(!rst));
    acc = lv && !rst;
    ok  = bcd_ok(lt);
    tk  = r && (m_pre == TICK_DIV - 1);
    e   = '0;
    if (rst) begin
      m_h = 0; m_m = 0; m_s = 0; m_pre = 0;
    end else if (acc && ok) begin
      m_h = int'(lt[23:20]) * 10 + int'(lt[19:16]);
      m_m = int'(lt[15:12]) * 10 + int'(lt[11:8]);
      m_s = int'(lt[7:4]) * 10 + int'(lt[3:0]);
      m_pre = 0;
    end else begin
      e.err = acc && !ok;
      if (tk && !acc) begin
        e.sp = 1'b1;
        m_s++;
        if (m_s == 60) begin
          m_s = 0; e.mp = 1'b1; m_m++;
          if (m_m == 60) begin
            m_m = 0; m_h++;
            if (m_h == 24) begin
              m_h = 0; e.dp = 1'b1;
            end
          end
        end
      end
      if (r) m_pre = (m_pre == TICK_DIV - 1) ? 0 : m_pre + 1;
    end
    e.t  = fmt(m_h, m_m, m_s, m12);
    e.pm = m12 && (m_h >= 12);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
    got = exp_q.pop_front();
    tg  = tag_q.pop_front();
    check({tg, " time_bcd"},  32'(time_bcd),  32'(got.t));
    check({tg, " pm"},        32'(pm),        32'(got.pm));
    check({tg, " sec_pulse"}, 32'(sec_pulse), 32'(got.sp));
    check({tg, " min_pulse"}, 32'(min_pulse), 32'(got.mp));
    check({tg, " day_pulse"}, 32'(day_pulse), 32'(got.dp));
    check({tg, " load_err"},  32'(load_err),  32'(got.err));
  endtask

  initial begin
    int guard;
    @(negedge clk);

    // Reset, including a load request that must be ignored
    step(1, 0, 24'h0, 1, 0, "reset");
    step(1, 1, 24'h101010, 1, 0, "reset_with_load");
    check("reset_load_ignored", 32'(time_bcd), 32'h000000);

    // Free run from release: advances on steps 4 and 8
    for (int i = 0; i < 9; i++) step(0, 0, 24'h0, 1, 0, "run_from_reset");
    check("two_seconds", 32'(time_bcd), 32'h000002);

    // Hold with run=0
    for (int i = 0; i < 5; i++) step(0, 0, 24'h0, 0, 0, "held");

    // Day wrap
    step(0, 1, 24'h235958, 1, 0, "load_235958");
    for (int i = 0; i < 8; i++) step(0, 0, 24'h0, 1, 0, "to_midnight");
    check("midnight_time", 32'(time_bcd), 32'h000000);
    check("midnight_day_pulse", 32'(day_pulse), 32'h1);

    // Rejected loads
    step(0, 1, 24'h245000, 0, 0, "bad_hour");
    step(0, 0, 24'h0, 0, 0, "after_bad_hour");
    step(0, 1, 24'h126099, 0, 0, "bad_min_sec");
    step(0, 0, 24'h0, 0, 0, "after_bad_min_sec");
    check("bad_loads_time", 32'(time_bcd), 32'h000000);

    // 12-hour display
    step(0, 1, 24'h000000, 0, 1, "load_midnight_12h");
    check("midnight_12h", 32'(time_bcd), 32'h120000);
    step(0, 1, 24'h133000, 0, 1, "load_1330_12h");
    check("1330_12h", 32'(time_bcd), 32'h013000);
    check("1330_12h_pm", 32'(pm), 32'h1);
    step(0, 0, 24'h0, 0, 0, "back_to_24h");
    check("1330_24h", 32'(time_bcd), 32'h133000);
    step(0, 1, 24'h120000, 0, 1, "noon_12h");

    // Hour tens carry
    step(0, 1, 24'h095959, 1, 0, "load_095959");
    for (int i = 0; i < 4; i++) step(0, 0, 24'h0, 1, 1, "hour_carry_12h");
    step(0, 0, 24'h0, 1, 0, "hour_carry_24h");
    check("ten_oclock", 32'(time_bcd), 32'h100000);

    // Load in the tick cycle
    guard = 0;
    while ((m_pre != TICK_DIV - 1) && (guard < 8)) begin
      step(0, 0, 24'h0, 1, 0, "align");
      guard++;
    end
    check("align_bound", 32'(m_pre), 32'(TICK_DIV - 1));
    step(0, 1, 24'h101010, 1, 0, "load_on_tick");
    check("load_on_tick_time", 32'(time_bcd), 32'h101010);
    check("load_on_tick_no_sec", 32'(sec_pulse), 32'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 24'h0, 1, 0, "after_tick_load");
    check("after_tick_load_time", 32'(time_bcd), 32'h101011);

    // Reset mid-phase
    step(0, 0, 24'h0, 1, 0, "pre_reset");
    step(0, 0, 24'h0, 1, 0, "pre_reset");
    step(1, 0, 24'h0, 1, 0, "mid_reset");
    for (int i = 0; i < 4; i++) step(0, 0, 24'h0, 1, 0, "after_mid_reset");
    check("after_mid_reset_time", 32'(time_bcd), 32'h000001);
    for (int i = 0; i < 3; i++) step(0, 0, 24'h0, 1, 0, "tail");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/time_of_day_counter.md
TIME_OF_DAY_COUNTER -- requirements
Module: time_of_day_counter

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clk cycles per one-second tick (legal range 2..2^26).
REQ-002 clk  input  1  system clock, all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 run  input  1  1 = time advances on ticks; 0 = prescaler and time held.
REQ-005 mode_12h  input  1  display format: 0 = 24-hour, 1 = 12-hour.
REQ-006 load_valid  input  1  load request, held until accepted.
REQ-007 load_time  input  24  BCD hh:mm:ss, always 24-hour format, [23:20] hour tens ... [3:0] second units.
REQ-008 load_ready  output  1  block can accept a load this cycle.
REQ-009 load_err  output  1  one-cycle pulse: accepted load was rejected as out of range.
REQ-010 time_bcd  output  24  current time in BCD, same digit order as load_time, formatted per mode_12h.
REQ-011 pm  output  1  12-hour mode: 1 when internal hour >= 12; 24-hour mode: 0.
REQ-012 sec_pulse / min_pulse / day_pulse  output  1 each  one-cycle carry strobes.

Function
REQ-013 Single clock domain; no derived clocks; tick is an enable, not a clock.
REQ-014 Prescaler counts 0..TICK_DIV-1 while run=1, wraps to 0; tick asserted in the cycle it equals TICK_DIV-1.
REQ-015 On tick, internal time advances one second, updated at the end of that cycle.
REQ-016 Carry chain: s 9->0 carries to s tens; 59 s ->00 carries to minutes; 59 min ->00 carries to hours; 23:59:59 -> 00:00:00.
REQ-017 sec_pulse is high for the one cycle in which the advanced time is first visible on time_bcd.
REQ-018 min_pulse is coincident with sec_pulse when seconds wrap to 00.
REQ-019 day_pulse is coincident with sec_pulse when time wraps to 00:00:00.
REQ-020 load_ready = 1 in every cycle except reset cycles.
REQ-021 Load is accepted when load_valid and load_ready are both 1.
REQ-022 A load is valid when hour 00..23, minute tens 0..5, second tens 0..5, and every units digit is 0..9.
REQ-023 A valid accepted load sets internal time to load_time and clears the prescaler to 0.
REQ-024 A valid load causes no pulse, and its time is visible on time_bcd in the next cycle.
REQ-025 An invalid accepted load leaves time and prescaler unchanged and pulses load_err for the next cycle.
REQ-026 Load and tick in the same cycle: the load wins, the tick is discarded, and no pulses are issued.
REQ-027 Load accepted while run=0: applied normally, prescaler stays at 0.
REQ-028 time_bcd and pm are a combinational decode of the internal registers and mode_12h; mode changes take effect immediately with no effect on the count.
REQ-029 12-hour decode: hour 00 -> 12, 01..12 unchanged, 13..23 -> hour-12, hour tens digit 0 or 1.
REQ-030 Internal time is always 24-hour BCD and never holds an illegal digit.

Reset
REQ-031 While reset=1: time 00:00:00, prescaler 0, all pulses and load_err 0, load_ready 0.
REQ-032 Reset overrides load and tick in the same cycle.
REQ-033 Reset mid-operation discards the prescaler phase, and counting restarts from 0 in the first cycle after release.

Structure
REQ-034 The shared package clock_pkg holds the BCD digit typedef, the hh:mm:ss time struct, constants for the maximum hour/minute/second digits, and a time-validity function reused by the alarm logic.
REQ-035 Sub-module tick_prescaler (parameter TICK_DIV; ports clk, reset, en, tick) is instantiated once; BCD carry and 12-hour decode stay in time_of_day_counter.
REQ-036 Target size 150-300 lines of RTL; no latches; one always block per register group.

Verification (TICK_DIV=4)
REQ-037 Release reset, run=1 -> time_bcd=000000, first sec_pulse 4 cycles after release, time 000001, then one advance every 4 cycles.
REQ-038 Load 0x235958, run=1 -> 0x235959 after 4 cycles, then 0x000000 after 4 more, with sec_pulse, min_pulse and day_pulse all high in that cycle.
REQ-039 Load 0x245000, then load 0x126099 -> load_err pulses each time, time_bcd unchanged, no carry pulses.
REQ-040 Load 0x000000 with mode_12h=1 -> time_bcd=0x120000, pm=0; load 0x133000 -> time_bcd=0x013000, pm=1; mode_12h=0 -> time_bcd=0x133000, pm=0.
REQ-041 Assert load_valid with 0x101010 in the cycle the prescaler equals 3 -> time 0x101010, no sec_pulse, next advance 4 cycles later; reset asserted with load_valid -> time 000000, load ignored.
